// File: rtl/window3x3_filter.sv
// 3x3 neighbourhood filter between two FIFOs: two line buffers feed a sliding window that
// produces a Sobel magnitude, a 1-2-1 Gaussian blur or a passthrough pixel, with image borders zeroed.
module window3x3_filter #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic              in_rd_en,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              out_wr_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int XW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam int CW   = $clog2(NPIX);
  localparam int SW   = DWIDTH + 4;
  localparam logic [DWIDTH-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [XW-1:0]     in_x, c_x;
  logic [YW-1:0]     in_y, c_y;
  logic [CW-1:0]     wr_cnt;
  logic [1:0]        mode_q;
  logic              res_valid;
  logic [DWIDTH-1:0] res_data;
  logic              drain_done;

  logic [DWIDTH-1:0] line1 [IMG_WIDTH];
  logic [DWIDTH-1:0] line2 [IMG_WIDTH];

  // Window columns: *0 = left (x-2), *1 = centre (x-1); the right column comes straight from the input
  logic [DWIDTH-1:0] win_t0, win_m0, win_b0, win_t1, win_m1, win_b1;
  logic [DWIDTH-1:0] col_t, col_m, col_b;

  logic entry_free, accept, load_run, load_drain, load;
  logic is_border, last_in, last_centre;

  assign entry_free  = ~res_valid | ~out_full;
  assign accept      = (state != DRAIN) & ~in_empty & entry_free;
  assign in_rd_en    = accept;
  assign out_wr_en   = res_valid & ~out_full;
  assign out_din     = res_data;
  assign busy        = (state != IDLE);
  assign frame_done  = out_wr_en & (wr_cnt == CW'(NPIX - 1));

  assign col_t = line2[in_x];
  assign col_m = line1[in_x];
  assign col_b = in_dout;

  // The first centre is ready once pixel W+1 (row 1, column 1) is accepted
  assign load_run    = accept & ((in_y > YW'(1)) | ((in_y == YW'(1)) & (in_x != '0)));
  assign load_drain  = (state == DRAIN) & entry_free & ~drain_done;
  assign load        = load_run | load_drain;

  assign last_in     = (in_x == XW'(IMG_WIDTH - 1)) & (in_y == YW'(IMG_HEIGHT - 1));
  assign last_centre = (c_x == XW'(IMG_WIDTH - 1)) & (c_y == YW'(IMG_HEIGHT - 1));
  assign is_border   = (c_x == '0) | (c_x == XW'(IMG_WIDTH - 1)) |
                       (c_y == '0) | (c_y == YW'(IMG_HEIGHT - 1));

  logic [SW-1:0]        sum_l, sum_r, sum_top, sum_mid, sum_bot, ax, ay, mag, gsum;
  logic signed [SW-1:0] gx, gy;
  logic [DWIDTH-1:0]    sobel_val, gauss_val, filt_val, result;

  // Filter arithmetic on the window centred one row up and one column left of the incoming pixel
  always_comb begin
    sum_l     = SW'(win_t0) + (SW'(win_m0) << 1) + SW'(win_b0);
    sum_r     = SW'(col_t)  + (SW'(col_m)  << 1) + SW'(col_b);
    sum_top   = SW'(win_t0) + (SW'(win_t1) << 1) + SW'(col_t);
    sum_mid   = SW'(win_m0) + (SW'(win_m1) << 1) + SW'(col_m);
    sum_bot   = SW'(win_b0) + (SW'(win_b1) << 1) + SW'(col_b);
    gx        = signed'(sum_r - sum_l);
    gy        = signed'(sum_bot - sum_top);
    ax        = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay        = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag       = (ax + ay) >> 1;
    sobel_val = (mag > SW'(PIX_MAX)) ? PIX_MAX : mag[DWIDTH-1:0];
    gsum      = sum_top + (sum_mid << 1) + sum_bot + SW'(8);
    gauss_val = gsum[SW-1:4];
    case (mode_q)
      2'd0:    filt_val = sobel_val;
      2'd1:    filt_val = gauss_val;
      default: filt_val = win_m1;
    endcase
    result = is_border ? '0 : filt_val;
  end

  // Line buffers are deliberately not reset; border forcing hides stale rows at frame start
  always_ff @(posedge clock) begin
    if (accept) begin
      line2[in_x] <= line1[in_x];
      line1[in_x] <= in_dout;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_x       <= '0;
      in_y       <= '0;
      c_x        <= '0;
      c_y        <= '0;
      wr_cnt     <= '0;
      mode_q     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      drain_done <= 1'b0;
      win_t0     <= '0;
      win_m0     <= '0;
      win_b0     <= '0;
      win_t1     <= '0;
      win_m1     <= '0;
      win_b1     <= '0;
    end else begin
      if (accept) begin
        if (in_x == XW'(IMG_WIDTH - 1)) begin
          in_x <= '0;
          in_y <= (in_y == YW'(IMG_HEIGHT - 1)) ? '0 : in_y + YW'(1);
        end else begin
          in_x <= in_x + XW'(1);
        end
        win_t0 <= win_t1;
        win_m0 <= win_m1;
        win_b0 <= win_b1;
        win_t1 <= col_t;
        win_m1 <= col_m;
        win_b1 <= col_b;
      end

      if (load) begin
        res_data <= result;
        if (c_x == XW'(IMG_WIDTH - 1)) begin
          c_x <= '0;
          c_y <= (c_y == YW'(IMG_HEIGHT - 1)) ? '0 : c_y + YW'(1);
        end else begin
          c_x <= c_x + XW'(1);
        end
      end

      if (load) begin
        res_valid <= 1'b1;
      end else if (out_wr_en) begin
        res_valid <= 1'b0;
      end

      if (out_wr_en) begin
        wr_cnt <= frame_done ? '0 : wr_cnt + CW'(1);
      end

      if (load & last_centre) begin
        drain_done <= 1'b1;
      end else if (frame_done) begin
        drain_done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            mode_q <= mode;
          end
        end
        RUN: begin
          if (accept & last_in) begin
            state <= DRAIN;
          end
        end
        default: begin
          if (frame_done) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window3x3_filter.sv
// Directed bench for window3x3_filter on an 8x6 image with FIFO models on both sides.
module tb_window3x3_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       in_rd_en;
  logic [7:0] in_dout = 8'd0;
  logic       in_empty = 1'b1;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       out_full = 1'b0;
  logic       busy;
  logic       frame_done;

  window3x3_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .in_rd_en(in_rd_en),
    .in_dout(in_dout),
    .in_empty(in_empty),
    .out_wr_en(out_wr_en),
    .out_din(out_din),
    .out_full(out_full),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  logic [7:0] in_q[$];
  int         out_q[$];
  int         fd_q[$];
  int         pops = 0;
  int         viol = 0;
  int         total = 0;
  int         passed = 0;
  int         failed = 0;
  bit         stall_en = 1'b0;
  bit         in_hold = 1'b0;
  int         exp_col [W];

  logic       s_rd, s_wr, s_fd;
  logic [7:0] s_dout;

  // Sample DUT handshakes mid-cycle; they take effect on the following rising edge
  always @(negedge clock) begin
    s_rd   = in_rd_en;
    s_wr   = out_wr_en;
    s_fd   = frame_done;
    s_dout = out_din;
    if (out_wr_en && out_full) viol++;
    if (in_rd_en && in_empty) viol++;
  end

  // FIFO models: pop/push on the edge, then present next-cycle FIFO state
  always @(posedge clock) begin
    if (reset) begin
      if (s_rd && in_q.size() > 0) begin
        void'(in_q.pop_front());
        pops++;
      end
      if (s_wr) begin
        out_q.push_back(int'(s_dout));
        if (s_fd) fd_q.push_back(out_q.size());
      end
    end
    #1;
    if (stall_en) begin
      out_full = 1'($urandom_range(0, 1));
      in_hold  = ($urandom_range(0, 2) == 0);
    end else begin
      out_full = 1'b0;
      in_hold  = 1'b0;
    end
    in_empty = (in_q.size() == 0) || in_hold;
    in_dout  = (in_q.size() > 0) ? in_q[0] : 8'd0;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push one frame whose columns 0-3 hold lo and columns 4-7 hold hi
  task automatic applyStimulus(input int lo, input int hi);
    for (int i = 0; i < NPIX; i++) in_q.push_back(((i % W) < 4) ? 8'(lo) : 8'(hi));
  endtask

  task automatic clearCapture();
    out_q.delete();
    fd_q.delete();
    pops = 0;
  endtask

  task automatic waitOutputs(input int n, input string tag);
    int cyc = 0;
    while (out_q.size() < n && cyc < 3000) begin
      @(posedge clock);
      cyc++;
    end
    repeat (20) @(posedge clock);
    #2;
    checkOutput({tag, " count"}, out_q.size(), n);
  endtask

  task automatic checkFrame(input int base, input string tag);
    for (int i = 0; i < NPIX; i++) begin
      int col = i % W;
      int row = i / W;
      int exp = (col == 0 || col == W - 1 || row == 0 || row == H - 1) ? 0 : exp_col[col];
      int obs = (base + i < out_q.size()) ? out_q[base + i] : -1;
      checkOutput($sformatf("%s px%0d", tag, i), obs, exp);
    end
  endtask

  task automatic waitFirstPop(input string tag);
    int cyc = 0;
    while (pops < 1 && cyc < 200) begin
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
    checkOutput({tag, " busy run"}, int'(busy), 1);
  endtask

  task automatic runFrame(input int lo, input int hi, input logic [1:0] m, input string tag);
    clearCapture();
    mode = m;
    applyStimulus(lo, hi);
    waitFirstPop(tag);
    waitOutputs(NPIX, tag);
    checkFrame(0, tag);
    checkOutput({tag, " done pulses"}, fd_q.size(), 1);
    checkOutput({tag, " done index"}, (fd_q.size() > 0) ? fd_q[0] : -1, NPIX);
    checkOutput({tag, " busy idle"}, int'(busy), 0);
  endtask

  initial begin
    #12;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset wr_en", int'(out_wr_en), 0);
    checkOutput("reset done", int'(frame_done), 0);
    checkOutput("reset rd_en", int'(in_rd_en), 0);
    @(posedge clock);
    #2 reset = 1'b1;

    exp_col = '{0, 0, 0, 0, 0, 0, 0, 0};
    runFrame(100, 100, 2'd0, "flat sobel");
    exp_col = '{0, 100, 100, 100, 100, 100, 100, 0};
    runFrame(100, 100, 2'd1, "flat gauss");
    runFrame(100, 100, 2'd2, "flat pass");

    exp_col = '{0, 0, 0, 255, 255, 0, 0, 0};
    runFrame(0, 255, 2'd0, "step255 sobel");
    exp_col = '{0, 0, 0, 80, 80, 0, 0, 0};
    runFrame(0, 40, 2'd0, "step40 sobel");
    exp_col = '{0, 0, 0, 10, 30, 40, 40, 0};
    runFrame(0, 40, 2'd1, "step40 gauss");
    exp_col = '{0, 0, 0, 0, 40, 40, 40, 0};
    runFrame(0, 40, 2'd3, "step40 pass3");

    stall_en = 1'b1;
    exp_col = '{0, 0, 0, 10, 30, 40, 40, 0};
    runFrame(0, 40, 2'd1, "stall gauss");
    exp_col = '{0, 0, 0, 80, 80, 0, 0, 0};
    runFrame(0, 40, 2'd0, "stall sobel");
    stall_en = 1'b0;
    repeat (3) @(posedge clock);

    // Abort a frame after 20 pixels, then a clean frame must come out intact
    clearCapture();
    mode = 2'd1;
    applyStimulus(100, 100);
    begin
      int cyc = 0;
      while (pops < 20 && cyc < 500) begin
        @(posedge clock);
        cyc++;
      end
      checkOutput("abort pops reached", int'(pops >= 20), 1);
    end
    #2 reset = 1'b0;
    in_q.delete();
    clearCapture();
    repeat (3) @(posedge clock);
    #3;
    checkOutput("abort busy in reset", int'(busy), 0);
    checkOutput("abort wr_en in reset", int'(out_wr_en), 0);
    #1 reset = 1'b1;
    exp_col = '{0, 100, 100, 100, 100, 100, 100, 0};
    runFrame(100, 100, 2'd1, "post-reset gauss");

    // Back-to-back frames; mode changes during frame 1 only affect frame 2
    clearCapture();
    mode = 2'd0;
    applyStimulus(0, 40);
    applyStimulus(0, 40);
    begin
      int cyc = 0;
      while (pops < 10 && cyc < 500) begin
        @(posedge clock);
        cyc++;
      end
    end
    #2 mode = 2'd1;
    waitOutputs(2 * NPIX, "b2b");
    exp_col = '{0, 0, 0, 80, 80, 0, 0, 0};
    checkFrame(0, "b2b f1 sobel");
    exp_col = '{0, 0, 0, 10, 30, 40, 40, 0};
    checkFrame(NPIX, "b2b f2 gauss");
    checkOutput("b2b done pulses", fd_q.size(), 2);
    checkOutput("b2b done idx1", (fd_q.size() > 0) ? fd_q[0] : -1, NPIX);
    checkOutput("b2b done idx2", (fd_q.size() > 1) ? fd_q[1] : -1, 2 * NPIX);

    checkOutput("handshake violations", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
